// File: rtl/serial_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_deserializer
// Description : Frame-aligned serial-to-parallel receiver with a one-deep
//               valid/ready output buffer, overrun and sync-error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_deserializer #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         sin_frame,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun,
    input  logic         clr_overrun,
    output logic         sync_err,
    output logic         busy
);

    localparam int                 c_CNT_W = $clog2(N);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [N-1:0]       r_sr;
    logic [N-1:0]       w_sr_nxt;
    logic [N-1:0]       w_sr_base;
    logic [N-1:0]       w_shifted;
    logic               w_restart;
    logic               w_complete;
    logic               w_pop;
    logic [N-1:0]       r_out_data;
    logic               r_out_valid;
    logic               r_overrun;
    logic               r_sync_err;

    // A framed bit always starts from an empty register, discarding any partial word.
    assign w_sr_base = ((r_state == ST_IDLE) || sin_frame) ? '0 : r_sr;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shifted = {sin, w_sr_base[N-1:1]};
        end else begin : g_msb_first
            assign w_shifted = {w_sr_base[N-2:0], sin};
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_sr_nxt    = r_sr;
        w_restart   = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sin_valid && sin_frame) begin
                    w_sr_nxt    = w_shifted;
                    w_count_nxt = c_ONE;
                    w_state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (sin_valid) begin
                    w_sr_nxt = w_shifted;
                    if (sin_frame) begin
                        w_restart   = 1'b1;
                        w_count_nxt = c_ONE;
                    end else if (r_count == c_LAST) begin
                        w_complete  = 1'b1;
                        w_count_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_count_nxt = r_count + c_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_sr       <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_sr       <= w_sr_nxt;
            r_sync_err <= w_restart;
        end
    end

    assign w_pop = r_out_valid && out_ready;

    // A pop on the completion edge refills the buffer without a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_complete && (!r_out_valid || w_pop)) begin
                r_out_data  <= w_shifted;
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end

            if (clr_overrun) begin
                r_overrun <= 1'b0;
            end else if (w_complete && r_out_valid && !w_pop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign sync_err  = r_sync_err;
    assign busy      = (r_state == ST_RECV);

endmodule
`default_nettype wire
